irq_dispatcher: RTL and testbench
=================================

# irq_dispatcher

Sequencer between `interrupt_controller` and the CPU interrupt port. Consumes the controller's pending/enabled status vector `isr` and selects one source at a time by fixed or round-robin priority. Presents that source's vector to the CPU with a request/acknowledge handshake, pulses the matching `isr_clear` bit on acknowledge, and holds off further requests until end-of-interrupt. An optional watchdog recovers from a missing end-of-interrupt.

## Interface
- `NUM_OF_IRQS`, 8: number of sources; must be ≥2.
- `ARB_MODE`, 1'b0: 0 = fixed priority, bit 0 highest; 1 = round-robin.
- `EOI_TIMEOUT`, 0: cycles allowed in SERVICE before forced exit; 0 disables the watchdog.
- `VEC_W`, `$clog2(NUM_OF_IRQS)`: vector width (derived, not overridden).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `isr`  in  NUM_OF_IRQS  pending-and-enabled status from `interrupt_controller`.
- `isr_clear`  out  NUM_OF_IRQS  one-hot, one-cycle clear pulse to `interrupt_controller`.
- `irq_req`  out  1  request to CPU.
- `irq_vec`  out  VEC_W  index of the requested source; stable while `irq_req`=1.
- `irq_ack`  in  1  CPU accepts the request.
- `eoi`  in  1  CPU end-of-interrupt, single-cycle pulse.
- `eoi_timeout`  out  1  sticky flag: watchdog fired.
- `eoi_timeout_clr`  in  1  clears `eoi_timeout`.

## Operation
- States: IDLE, REQ, SERVICE.
- **IDLE:** if `|isr`, the picker returns the winner, which is latched into `vec_q`; next state is REQ. Otherwise stay in IDLE.
- **REQ:** `irq_req`=1 and `irq_vec`=`vec_q`.
  - `irq_ack`=1 → register `isr_clear` = one-hot(`vec_q`) for exactly one cycle; next state is SERVICE.
  - `irq_ack`=0 and `isr[vec_q]`=0 (source withdrawn) → next state is IDLE; no clear is issued.
  - `irq_ack`=1 and `isr[vec_q]`=0 in the same cycle → acknowledge wins and the clear is still issued.
- **SERVICE:** `irq_req`=0.
  - `eoi`=1 → next state is IDLE. In round-robin mode, `ptr` ← `vec_q`+1, wrapping `NUM_OF_IRQS-1` → 0.
  - If `EOI_TIMEOUT`>0, the watchdog counter increments every SERVICE cycle. When it reaches `EOI_TIMEOUT`, set `eoi_timeout`, go to IDLE, and update `ptr` exactly as on EOI.
  - `eoi` in the same cycle as expiry → treated as a normal EOI; no flag is set.
  - The watchdog counter is zeroed on every entry to SERVICE.
- **Ignored inputs:** `irq_ack` outside REQ and `eoi` outside SERVICE have no effect.
- **Priority:**
  - Fixed mode: the lowest set index wins.
  - Round-robin mode: the first set index at or above `ptr`, wrapping, wins.
  - In fixed mode `ptr` is held at 0.
- **Error flag:** `eoi_timeout` clears on `eoi_timeout_clr`. Set has priority over clear in the same cycle.
- **Reset:** all outputs are 0 (`isr_clear`=0, `irq_req`=0, `irq_vec`=0, `eoi_timeout`=0), state is IDLE, `ptr`=0, watchdog counter 0. Reset asserted mid-operation aborts immediately and no clear is issued.

## Timing
- All outputs are registered; no combinational input→output path.
- `isr` bit seen high at edge n → `irq_req`=1 from edge n+1.
- `irq_ack` sampled at edge k → `isr_clear` high during the cycle after edge k only; `irq_req` low from edge k as well.
- `eoi` sampled at edge m → state is IDLE after edge m. The next `irq_req` rises at edge m+2 at the earliest, giving a minimum of 2 idle request cycles between services.
- Withdrawal is seen at edge w → `irq_req` is low after edge w.
- Watchdog: entry to SERVICE at edge s with no `eoi` → `eoi_timeout`=1 and IDLE after edge s+`EOI_TIMEOUT`.
- Watchdog counter width is `$clog2(EOI_TIMEOUT+1)`; it saturates and never wraps.

## Structure
- Package `irq_dispatcher_pkg` holds:
  - the `state_t` enum (IDLE, REQ, SERVICE);
  - `ARB_FIXED` / `ARB_RR` constants.
- Sub-module `irq_priority_picker`: combinational rotating priority encoder.
  - Inputs: `req` vector and `ptr`.
  - Outputs: `valid` and `idx`.
  - Fixed mode instantiates it with `ptr` tied to 0.
- The top level contains the FSM, the `vec_q`/`ptr` registers, the watchdog and the output registers.

## Test plan
- **Fixed priority:** `ARB_MODE`=0, `isr`=8'h24 held → `irq_req`=1, `irq_vec`=2 one cycle later. Then:
  - `irq_ack` → `isr_clear`=8'h04 for one cycle; drive `isr`=8'h20.
  - `eoi` → `irq_vec`=5 two cycles after `eoi`.
- **Round-robin:** `ARB_MODE`=1, `isr`=8'h81 held, and the bench does not drop bits on clear → service order is 0, 7, 0, 7 across four ack/eoi rounds.
- **Withdrawal:** enter REQ with `irq_vec`=3, drop `isr[3]` without ack → `irq_req`=0 after the next edge, `isr_clear` stays 0. Simultaneous ack + drop → `isr_clear`=8'h08.
- **Watchdog:** `EOI_TIMEOUT`=4, ack and no `eoi` → `eoi_timeout`=1 and state IDLE four edges after entering SERVICE. `eoi_timeout_clr` → flag returns to 0.
- **Reset mid-operation:** assert `rst_n`=0 while in SERVICE with `ptr`=5 → all outputs 0 immediately. After release with `isr`=8'h60 in RR mode, `irq_vec`=5 (`ptr` reset to 0, so the lowest set index wins).
- **Stray inputs:** `irq_ack` in IDLE/SERVICE and `eoi` in IDLE/REQ → no state change and no `isr_clear` pulse.

Source files
------------

// File: rtl/irq_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// irq_dispatcher_pkg
//   Shared types and constants for the interrupt dispatcher slice.
//   - state_t   : dispatcher sequencer states (IDLE, REQ, SERVICE)
//   - ARB_FIXED : arbitration mode value for fixed priority (bit 0 highest)
//   - ARB_RR    : arbitration mode value for round-robin priority
// ---------------------------------------------------------------------------
package irq_dispatcher_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/irq_priority_picker.sv
// ---------------------------------------------------------------------------
// irq_priority_picker
//   Combinational rotating priority encoder. Starting at index ptr and
//   wrapping around, returns the first index whose req bit is set.
//   With ptr tied to 0 it degenerates to a plain lowest-index-wins encoder.
//
// Ports
//   req   in  NUM_OF_IRQS  request vector
//   ptr   in  VEC_W        index that currently has the highest priority
//   valid out 1            at least one request bit is set
//   idx   out VEC_W        winning index (0 when valid=0)
// ---------------------------------------------------------------------------
module irq_priority_picker #(
    parameter  int NUM_OF_IRQS = 8,
    localparam int VEC_W       = $clog2(NUM_OF_IRQS)
) (
    input  logic [NUM_OF_IRQS-1:0] req,
    input  logic [VEC_W-1:0]       ptr,
    output logic                   valid,
    output logic [VEC_W-1:0]       idx
);

    int               cand;
    logic [VEC_W-1:0] cand_idx;

    // Scan offsets from the farthest to the nearest so that the smallest
    // offset from ptr (the highest priority) is the last one to write idx.
    always_comb begin
        cand     = 0;
        cand_idx = '0;
        valid    = 1'b0;
        idx      = '0;
        for (int off = NUM_OF_IRQS - 1; off >= 0; off--) begin
            cand     = (int'(ptr) + off) % NUM_OF_IRQS;
            cand_idx = VEC_W'(cand);
            if (req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/irq_dispatcher.sv
// ---------------------------------------------------------------------------
// irq_dispatcher
//   Sequencer between interrupt_controller and the CPU interrupt port.
//   Picks one pending source at a time (fixed or round-robin priority),
//   requests the CPU with irq_req/irq_vec, pulses the matching isr_clear
//   bit when the CPU acknowledges, then waits for end-of-interrupt before
//   looking at the sources again. An optional watchdog forces the exit from
//   SERVICE when no eoi arrives within EOI_TIMEOUT cycles.
//
// Parameters
//   NUM_OF_IRQS  number of sources (>= 2)
//   ARB_MODE     ARB_FIXED (bit 0 highest) or ARB_RR (round-robin)
//   EOI_TIMEOUT  SERVICE cycles before forced exit; 0 disables the watchdog
//
// Ports
//   clk             in  1            clock, all state on rising edge
//   rst_n           in  1            asynchronous active-low reset
//   isr             in  NUM_OF_IRQS  pending-and-enabled sources
//   isr_clear       out NUM_OF_IRQS  one-hot, one-cycle clear pulse
//   irq_req         out 1            request to CPU
//   irq_vec         out VEC_W        requested source, stable while irq_req=1
//   irq_ack         in  1            CPU accepts the request
//   eoi             in  1            CPU end-of-interrupt pulse
//   eoi_timeout     out 1            sticky: watchdog fired
//   eoi_timeout_clr in  1            clears eoi_timeout
// ---------------------------------------------------------------------------
module irq_dispatcher
    import irq_dispatcher_pkg::*;
#(
    parameter  int   NUM_OF_IRQS = 8,
    parameter  logic ARB_MODE    = 1'b0,
    parameter  int   EOI_TIMEOUT = 0,
    localparam int   VEC_W       = $clog2(NUM_OF_IRQS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_OF_IRQS-1:0] isr,
    output logic [NUM_OF_IRQS-1:0] isr_clear,
    output logic                   irq_req,
    output logic [VEC_W-1:0]       irq_vec,
    input  logic                   irq_ack,
    input  logic                   eoi,
    output logic                   eoi_timeout,
    input  logic                   eoi_timeout_clr
);

    // A disabled watchdog still gets a 1-bit counter so no zero-width vector
    // appears; it is never incremented in that case.
    localparam int               WD_W    = (EOI_TIMEOUT > 0) ? $clog2(EOI_TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = (EOI_TIMEOUT > 0) ? WD_W'(EOI_TIMEOUT - 1) : '0;
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(EOI_TIMEOUT);
    localparam logic [VEC_W-1:0] VEC_TOP = VEC_W'(NUM_OF_IRQS - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [VEC_W-1:0]       vec_q;
    logic [VEC_W-1:0]       vec_d;
    logic [VEC_W-1:0]       ptr_q;
    logic [VEC_W-1:0]       ptr_d;
    logic [WD_W-1:0]        wd_cnt_q;
    logic [WD_W-1:0]        wd_cnt_d;
    logic [NUM_OF_IRQS-1:0] clear_d;
    logic                   req_d;
    logic                   set_timeout;

    logic                   pick_valid;
    logic [VEC_W-1:0]       pick_idx;
    logic [VEC_W-1:0]       pick_ptr;
    logic [VEC_W-1:0]       ptr_after;
    logic                   ack_eff;
    logic                   src_live;
    logic                   wd_expire;

    // Fixed mode always starts the scan at index 0.
    assign pick_ptr = (ARB_MODE == ARB_RR) ? ptr_q : '0;

    irq_priority_picker #(
        .NUM_OF_IRQS (NUM_OF_IRQS)
    ) u_picker (
        .req   (isr),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // The source just serviced becomes the lowest priority next round.
    assign ptr_after = (vec_q == VEC_TOP) ? '0 : vec_q + VEC_W'(1);

    // An ack is only meaningful once the request is actually visible to the
    // CPU; the first REQ cycle (irq_req still low) cannot be acknowledged.
    assign ack_eff   = irq_ack && irq_req;
    assign src_live  = isr[vec_q];
    assign wd_expire = (EOI_TIMEOUT > 0) && (wd_cnt_q == WD_LAST);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        ptr_d       = ptr_q;
        wd_cnt_d    = wd_cnt_q;
        clear_d     = '0;
        req_d       = 1'b0;
        set_timeout = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    vec_d   = pick_idx;
                    state_d = REQ;
                end
            end

            REQ: begin
                // Acknowledge wins over a simultaneous withdrawal.
                if (ack_eff) begin
                    clear_d  = NUM_OF_IRQS'(1) << vec_q;
                    wd_cnt_d = '0;
                    state_d  = SERVICE;
                end else if (!src_live) begin
                    state_d = IDLE;
                end else begin
                    req_d = 1'b1;
                end
            end

            SERVICE: begin
                // A real eoi in the expiry cycle is a normal exit, no flag.
                if (eoi || wd_expire) begin
                    state_d     = IDLE;
                    set_timeout = !eoi;
                    if (ARB_MODE == ARB_RR) begin
                        ptr_d = ptr_after;
                    end
                end else if ((EOI_TIMEOUT > 0) && (wd_cnt_q != WD_MAX)) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            wd_cnt_q    <= '0;
            isr_clear   <= '0;
            irq_req     <= 1'b0;
            irq_vec     <= '0;
            eoi_timeout <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wd_cnt_q  <= wd_cnt_d;
            isr_clear <= clear_d;
            irq_req   <= req_d;
            if (req_d) begin
                irq_vec <= vec_q;
            end
            // Set has priority over clear.
            if (set_timeout) begin
                eoi_timeout <= 1'b1;
            end else if (eoi_timeout_clr) begin
                eoi_timeout <= 1'b0;
            end
        end
    end

    // Selected source index; only consulted outside IDLE, so no reset needed.
    always_ff @(posedge clk) begin
        vec_q <= vec_d;
    end

endmodule

// File: tb/tb_irq_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_irq_dispatcher
//   Directed bench for irq_dispatcher. Two instances share clock and reset:
//   dut_fix (fixed priority, watchdog off) and dut_rr (round-robin,
//   EOI_TIMEOUT=4). Inputs change 1 ns after the rising edge; outputs are
//   sampled at that same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_irq_dispatcher;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] f_isr    = '0;
    logic [7:0] f_clear;
    logic       f_req;
    logic [2:0] f_vec;
    logic       f_ack    = 1'b0;
    logic       f_eoi    = 1'b0;
    logic       f_to;
    logic       f_to_clr = 1'b0;

    logic [7:0] r_isr    = '0;
    logic [7:0] r_clear;
    logic       r_req;
    logic [2:0] r_vec;
    logic       r_ack    = 1'b0;
    logic       r_eoi    = 1'b0;
    logic       r_to;
    logic       r_to_clr = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    irq_dispatcher #(
        .NUM_OF_IRQS (8),
        .ARB_MODE    (1'b0),
        .EOI_TIMEOUT (0)
    ) dut_fix (
        .clk             (clk),
        .rst_n           (rst_n),
        .isr             (f_isr),
        .isr_clear       (f_clear),
        .irq_req         (f_req),
        .irq_vec         (f_vec),
        .irq_ack         (f_ack),
        .eoi             (f_eoi),
        .eoi_timeout     (f_to),
        .eoi_timeout_clr (f_to_clr)
    );

    irq_dispatcher #(
        .NUM_OF_IRQS (8),
        .ARB_MODE    (1'b1),
        .EOI_TIMEOUT (4)
    ) dut_rr (
        .clk             (clk),
        .rst_n           (rst_n),
        .isr             (r_isr),
        .isr_clear       (r_clear),
        .irq_req         (r_req),
        .irq_vec         (r_vec),
        .irq_ack         (r_ack),
        .eoi             (r_eoi),
        .eoi_timeout     (r_to),
        .eoi_timeout_clr (r_to_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [2:0] rr_exp [4];
        rr_exp[0] = 3'd0;
        rr_exp[1] = 3'd7;
        rr_exp[2] = 3'd0;
        rr_exp[3] = 3'd7;

        // Reset state
        #12;
        check_eq("rst_f_req",   f_req,   0);
        check_eq("rst_f_vec",   f_vec,   0);
        check_eq("rst_f_clear", f_clear, 0);
        check_eq("rst_f_to",    f_to,    0);
        check_eq("rst_r_req",   r_req,   0);
        check_eq("rst_r_to",    r_to,    0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fixed priority: 0x24 -> source 2 first
        f_isr = 8'h24;
        step();
        check_eq("fix_req_lat", f_req, 0);
        step();
        check_eq("fix_req",   f_req,   1);
        check_eq("fix_vec2",  f_vec,   2);
        check_eq("fix_noclr", f_clear, 0);
        f_ack = 1'b1;
        step();
        check_eq("fix_clr04",    f_clear, 8'h04);
        check_eq("fix_req_drop", f_req,   0);
        f_ack = 1'b0;
        f_isr = 8'h20;
        step();
        check_eq("fix_clr_1cyc", f_clear, 0);
        // Stray ack in SERVICE
        f_ack = 1'b1;
        step();
        check_eq("stray_ack_svc_clr", f_clear, 0);
        check_eq("stray_ack_svc_req", f_req,   0);
        f_ack = 1'b0;
        f_eoi = 1'b1;
        step();
        f_eoi = 1'b0;
        step();
        check_eq("fix_gap", f_req, 0);
        step();
        check_eq("fix_req5", f_req, 1);
        check_eq("fix_vec5", f_vec, 5);
        // Stray eoi in REQ
        f_eoi = 1'b1;
        step();
        f_eoi = 1'b0;
        check_eq("stray_eoi_req_req", f_req,   1);
        check_eq("stray_eoi_req_vec", f_vec,   5);
        check_eq("stray_eoi_req_clr", f_clear, 0);

        // Withdrawal: drop source 5, then serve 3 and withdraw it
        f_isr = 8'h00;
        step();
        check_eq("wd5_req", f_req, 0);
        f_isr = 8'h08;
        step();
        step();
        check_eq("wdr_req",  f_req, 1);
        check_eq("wdr_vec3", f_vec, 3);
        f_isr = 8'h00;
        step();
        check_eq("wdr_req_low", f_req,   0);
        check_eq("wdr_noclr",   f_clear, 0);
        step();
        check_eq("wdr_noclr2", f_clear, 0);
        check_eq("wdr_idle",   f_req,   0);
        // Simultaneous ack and withdrawal: ack wins
        f_isr = 8'h08;
        step();
        step();
        check_eq("sim_req", f_req, 1);
        f_isr = 8'h00;
        f_ack = 1'b1;
        step();
        f_ack = 1'b0;
        check_eq("sim_clr08", f_clear, 8'h08);
        check_eq("sim_req0",  f_req,   0);
        step();
        check_eq("sim_clr_end", f_clear, 0);
        // Watchdog disabled: long SERVICE never flags
        repeat (10) step();
        check_eq("fix_no_to", f_to, 0);
        f_eoi = 1'b1;
        step();
        f_eoi = 1'b0;
        // Stray ack/eoi in IDLE
        f_ack = 1'b1;
        step();
        step();
        check_eq("stray_ack_idle_req", f_req,   0);
        check_eq("stray_ack_idle_clr", f_clear, 0);
        f_ack = 1'b0;
        f_eoi = 1'b1;
        step();
        f_eoi = 1'b0;
        check_eq("stray_eoi_idle_req", f_req, 0);
        f_isr = 8'h01;
        step();
        step();
        check_eq("post_stray_req",  f_req, 1);
        check_eq("post_stray_vec0", f_vec, 0);
        f_isr = 8'h00;

        // Round-robin: 0x81 held -> 0,7,0,7
        r_isr = 8'h81;
        for (int i = 0; i < 4; i++) begin
            step();
            step();
            check_eq($sformatf("rr_req%0d", i), r_req, 1);
            check_eq($sformatf("rr_vec%0d", i), r_vec, 32'(rr_exp[i]));
            r_ack = 1'b1;
            step();
            r_ack = 1'b0;
            check_eq($sformatf("rr_clr%0d", i), r_clear, 32'(8'd1 << rr_exp[i]));
            r_eoi = 1'b1;
            step();
            r_eoi = 1'b0;
        end

        // Watchdog: source 4, no eoi, clear held on the expiry edge
        r_isr = 8'h10;
        step();
        step();
        check_eq("wdg_vec4", r_vec, 4);
        r_ack = 1'b1;
        step();
        r_ack = 1'b0;
        r_isr = 8'h00;
        step();
        step();
        step();
        check_eq("wdg_early", r_to, 0);
        r_to_clr = 1'b1;
        step();
        r_to_clr = 1'b0;
        check_eq("wdg_fire", r_to, 1);
        // Back in IDLE with ptr=5: 0x30 must pick 5
        r_isr = 8'h30;
        step();
        r_to_clr = 1'b1;
        step();
        r_to_clr = 1'b0;
        check_eq("wdg_clr",     r_to,  0);
        check_eq("wdg_ptr_req", r_req, 1);
        check_eq("wdg_ptr_vec", r_vec, 5);
        r_ack = 1'b1;
        step();
        r_ack = 1'b0;
        check_eq("pre_rst_clr", r_clear, 8'h20);

        // Reset in SERVICE with ptr=5
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_clr", r_clear, 0);
        check_eq("mid_rst_req", r_req,   0);
        check_eq("mid_rst_vec", r_vec,   0);
        check_eq("mid_rst_to",  r_to,    0);
        @(negedge clk);
        rst_n = 1'b1;
        r_isr = 8'h60;
        step();
        step();
        check_eq("post_rst_req",  r_req, 1);
        check_eq("post_rst_vec5", r_vec, 5);
        r_ack = 1'b1;
        step();
        r_ack = 1'b0;
        r_eoi = 1'b1;
        step();
        r_eoi = 1'b0;
        step();
        step();
        check_eq("rr_next_vec6", r_vec, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
